cpu_bus_responder: RTL

CPU_BUS_RESPONDER -- requirements
Module: cpu_bus_responder

---
 rtl/cpu_bus_responder.sv | 114 +++++++++++
 1 files changed

// File: rtl/cpu_bus_responder.sv
// rtl/cpu_bus_responder.sv - program/data memory responder for a 4-bit CPU bus
// Host loads a 32-nibble program; CPU fetches nibbles, jumps, and reads/writes a 16-nibble RAM.
module cpu_bus_responder (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] I_D,
  input  logic       MAR,
  input  logic       WRITE,
  input  logic       JMP,
  input  logic       I,
  input  logic       LD_EN,
  input  logic [3:0] LD_D,
  output logic [3:0] O_D,
  output logic       ERR
);

  typedef enum logic [1:0] {ST_RUN, ST_JMP_HI, ST_LOAD} state_t;

  state_t     state_q, state_d;
  logic [4:0] pc_q, pc_d;
  logic [4:0] ld_ptr_q, ld_ptr_d;
  logic [3:0] mar_q, mar_d;
  logic [3:0] jlo_q, jlo_d;
  logic [3:0] o_d_q, o_d_d;
  logic       err_q, err_d;
  logic       ram_we;
  logic       prog_we;

  logic [3:0] prog [32];
  logic [3:0] ram_q [16];

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ld_ptr_d = ld_ptr_q;
    mar_d    = mar_q;
    jlo_d    = jlo_q;
    o_d_d    = o_d_q;
    err_d    = err_q;
    ram_we   = 1'b0;
    prog_we  = 1'b0;

    if (LD_EN) begin
      state_d  = ST_LOAD;
      prog_we  = 1'b1;
      ld_ptr_d = ld_ptr_q + 5'd1;
      o_d_d    = 4'd0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          state_d  = ST_RUN;
          pc_d     = 5'd0;
          ld_ptr_d = 5'd0;
          o_d_d    = prog[0];
        end
        ST_JMP_HI: begin
          // Second jump nibble: only bit 0 is meaningful, all other strobes are protocol errors.
          state_d = ST_RUN;
          pc_d    = {I_D[0], jlo_q};
          o_d_d   = prog[pc_d];
          if (MAR || WRITE || JMP) err_d = 1'b1;
        end
        default: begin
          if (JMP) begin
            jlo_d   = I_D;
            state_d = ST_JMP_HI;
          end else if (MAR) begin
            mar_d = I_D;
            if (WRITE) err_d = 1'b1;
          end else if (WRITE) begin
            ram_we = 1'b1;
          end else if (I) begin
            pc_d = pc_q + 5'd1;
          end
          // RAM readback forwards a same-edge write so the CPU sees the new value.
          if (I) o_d_d = prog[pc_d];
          else if (ram_we) o_d_d = I_D;
          else o_d_d = ram_q[mar_d];
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_RUN;
      pc_q     <= 5'd0;
      ld_ptr_q <= 5'd0;
      mar_q    <= 4'd0;
      jlo_q    <= 4'd0;
      o_d_q    <= 4'd0;
      err_q    <= 1'b0;
      for (int k = 0; k < 16; k++) ram_q[k] <= 4'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ld_ptr_q <= ld_ptr_d;
      mar_q    <= mar_d;
      jlo_q    <= jlo_d;
      o_d_q    <= o_d_d;
      err_q    <= err_d;
      if (ram_we) ram_q[mar_q] <= I_D;
    end
  end

  // Program store has no reset so its contents survive RST; writes are blocked while RST is high.
  always_ff @(posedge CLK) begin
    if (prog_we && !RST) prog[ld_ptr_q] <= LD_D;
  end

  assign O_D = o_d_q;
  assign ERR = err_q;

endmodule
